// File: rtl/mem_bank_pkg.sv
// Shared types and constants for the protected memory bank.
// The response struct carries a fixed-width data field wide enough for any supported DATA_WIDTH.
package mem_bank_pkg;

  localparam int ERR_CNT_W  = 16;
  localparam int RSP_DW_MAX = 128;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [RSP_DW_MAX-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response delay line; reset empties every stage so no response survives it.
module mem_rsp_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [LATENCY];

  // Shift register: stage 0 captures at accept, the last stage drives the response.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[LATENCY-1];

endmodule

// File: rtl/mem_bank_prot.sv
// Single-port memory bank with a write-protected low region, self-initialisation (mem[n] = n)
// and a pipelined, fixed-latency response path.
module mem_bank_prot
  import mem_bank_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int RO_WORDS_RST = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic                    o_ready,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_err,
  input  logic                    i_prot_we,
  input  logic [ADDR_WIDTH:0]     i_prot_bound,
  output logic [ADDR_WIDTH:0]     o_prot_bound,
  input  logic                    i_err_clr,
  output logic [ERR_CNT_W-1:0]    o_err_cnt,
  output logic                    o_init_busy
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NLANES = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH:0] BOUND_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] BOUND_RST =
    (RO_WORDS_RST > DEPTH) ? BOUND_MAX : (ADDR_WIDTH+1)'(RO_WORDS_RST);

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [ADDR_WIDTH:0]     bound;
  logic [ERR_CNT_W-1:0]    err_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic accept;
  logic in_ro;
  logic wr_err;
  logic wr_ok;
  logic err_inc;
  rsp_t rsp_in;
  rsp_t rsp_out;
  logic unused_rsp_bits;

  assign accept  = i_req && (state == RUN);
  assign in_ro   = ({1'b0, i_addr} < bound);
  // A write with no enabled lane touches nothing, so it cannot violate protection.
  assign wr_err  = i_we && in_ro && (|i_strb);
  assign wr_ok   = accept && i_we && !in_ro;
  assign err_inc = accept && wr_err;

  // FSM: INIT walks every word once, then RUN forever until reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
            state <= RUN;
          end else begin
            state <= INIT;
          end
        end
        RUN: begin
          state    <= RUN;
          init_cnt <= init_cnt;
        end
        default: begin
          state    <= INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  // Storage write port: init pattern during INIT, byte-lane writes during RUN.
  always_ff @(posedge i_clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= DATA_WIDTH'(init_cnt);
    end else if (wr_ok) begin
      for (int k = 0; k < NLANES; k++) begin
        if (i_strb[k]) begin
          mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  // Protection boundary; an accept in the loading cycle still compares against the old value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bound <= BOUND_RST;
    end else if (i_prot_we) begin
      bound <= (i_prot_bound > BOUND_MAX) ? BOUND_MAX : i_prot_bound;
    end else begin
      bound <= bound;
    end
  end

  // Saturating error counter; a clear coinciding with a new error leaves exactly that error.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt <= '0;
    end else if (i_err_clr) begin
      err_cnt <= err_inc ? ERR_CNT_W'(1) : '0;
    end else if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  // Response entering the pipe; read data is zero for writes and idle cycles.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.err   = err_inc;
    if (accept && !i_we) begin
      rsp_in.rdata[DATA_WIDTH-1:0] = mem[i_addr];
    end else begin
      rsp_in.rdata = '0;
    end
  end

  mem_rsp_pipe #(
    .WIDTH   ($bits(rsp_t)),
    .LATENCY (RD_LATENCY)
  ) u_rsp_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (rsp_in),
    .q       (rsp_out)
  );

  assign unused_rsp_bits = ^rsp_out.rdata;

  assign o_rsp_valid  = rsp_out.valid;
  assign o_err        = rsp_out.err;
  assign o_rdata      = rsp_out.rdata[DATA_WIDTH-1:0];
  assign o_ready      = (state == RUN);
  assign o_init_busy  = (state == INIT);
  assign o_prot_bound = bound;
  assign o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_mem_bank_prot.sv
// Directed bench for mem_bank_prot built with RD_LATENCY = 2; expected values are hand-computed.
module tb_mem_bank_prot;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        prot_we;
  logic [7:0]  prot_bound;
  logic [7:0]  prot_bound_q;
  logic        err_clr;
  logic [15:0] err_cnt;
  logic        init_busy;

  int checks = 0;
  int errors = 0;
  int n_busy;
  int n_stray;

  mem_bank_prot #(
    .ADDR_WIDTH   (7),
    .DATA_WIDTH   (32),
    .RD_LATENCY   (2),
    .RO_WORDS_RST (64)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_we         (we),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_strb       (strb),
    .o_ready      (ready),
    .o_rsp_valid  (rsp_valid),
    .o_rdata      (rdata),
    .o_err        (err),
    .i_prot_we    (prot_we),
    .i_prot_bound (prot_bound),
    .o_prot_bound (prot_bound_q),
    .i_err_clr    (err_clr),
    .o_err_cnt    (err_cnt),
    .o_init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then check the response lands exactly two cycles after accept.
  task automatic req_rsp(input logic w, input logic [6:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_err, input logic [31:0] exp_rd,
                         input string tag);
    req = 1'b1; we = w; addr = a; wdata = d; strb = s;
    tick();
    req = 1'b0; we = 1'b0; strb = 4'h0; prot_we = 1'b0; err_clr = 1'b0;
    chk({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata, exp_rd);
  endtask

  task automatic wait_init(output int n, output int stray);
    n = 0;
    stray = 0;
    while (init_busy && n < 400) begin
      n++;
      if (rsp_valid) stray++;
      tick();
    end
  endtask

  task automatic load_bound(input logic [7:0] b);
    prot_we = 1'b1; prot_bound = b;
    tick();
    prot_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 7'd0; wdata = 32'd0; strb = 4'h0;
    prot_we = 1'b0; prot_bound = 8'd0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_bound", {24'd0, prot_bound_q}, 32'd64);
    chk("rst_errcnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    rst_n = 1'b1;
    wait_init(n_busy, n_stray);
    chk("init_cycles", n_busy, 32'd128);
    chk("init_ready", {31'd0, ready}, 32'd1);

    req_rsp(1'b0, 7'd0,   32'd0, 4'h0, 1'b0, 32'd0,   "rd0");
    req_rsp(1'b0, 7'd5,   32'd0, 4'h0, 1'b0, 32'd5,   "rd5");
    req_rsp(1'b0, 7'd127, 32'd0, 4'h0, 1'b0, 32'd127, "rd127");

    req_rsp(1'b1, 7'd100, 32'hDEADBEEF, 4'b0101, 1'b0, 32'd0, "wr100");
    req_rsp(1'b0, 7'd100, 32'd0, 4'h0, 1'b0, 32'h00AD00EF, "rd100");

    req_rsp(1'b1, 7'd10, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd0, "wr10_prot");
    chk("errcnt_1", {16'd0, err_cnt}, 32'd1);
    req_rsp(1'b0, 7'd10, 32'd0, 4'h0, 1'b0, 32'd10, "rd10");
    req_rsp(1'b1, 7'd10, 32'hFFFFFFFF, 4'h0, 1'b0, 32'd0, "wr10_nostrb");
    chk("errcnt_nostrb", {16'd0, err_cnt}, 32'd1);

    // Boundary load in the same cycle as the write: old boundary 64 still applies.
    prot_we = 1'b1; prot_bound = 8'd8;
    req_rsp(1'b1, 7'd20, 32'h11111111, 4'hF, 1'b1, 32'd0, "wr20_oldbound");
    chk("bound_8", {24'd0, prot_bound_q}, 32'd8);
    chk("errcnt_2", {16'd0, err_cnt}, 32'd2);
    req_rsp(1'b1, 7'd20, 32'h12345678, 4'hF, 1'b0, 32'd0, "wr20_ok");
    req_rsp(1'b0, 7'd20, 32'd0, 4'h0, 1'b0, 32'h12345678, "rd20");

    // Back-to-back write then read of the same word.
    req = 1'b1; we = 1'b1; addr = 7'd70; wdata = 32'hCAFEF00D; strb = 4'hF;
    tick();
    we = 1'b0; strb = 4'h0;
    chk("b2b_t1_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    req = 1'b0;
    chk("b2b_wr_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_wr_rdata", rdata, 32'd0);
    tick();
    chk("b2b_rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rd_err", {31'd0, err}, 32'd0);
    chk("b2b_rd_rdata", rdata, 32'hCAFEF00D);
    tick();
    chk("b2b_idle", {31'd0, rsp_valid}, 32'd0);

    load_bound(8'd200);
    chk("bound_clamp", {24'd0, prot_bound_q}, 32'd128);
    req_rsp(1'b1, 7'd127, 32'd1, 4'h1, 1'b1, 32'd0, "wr127_allro");
    chk("errcnt_3", {16'd0, err_cnt}, 32'd3);
    load_bound(8'd0);
    req_rsp(1'b1, 7'd0, 32'h000000FF, 4'h1, 1'b0, 32'd0, "wr0_allrw");
    req_rsp(1'b0, 7'd0, 32'd0, 4'h0, 1'b0, 32'h000000FF, "rd0_new");

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errcnt_clr", {16'd0, err_cnt}, 32'd0);
    load_bound(8'd128);
    err_clr = 1'b1;
    req_rsp(1'b1, 7'd5, 32'd0, 4'hF, 1'b1, 32'd0, "wr5_clr");
    chk("errcnt_clr_inc", {16'd0, err_cnt}, 32'd1);

    // Reset with a read still inside the pipe: it must never appear.
    req = 1'b1; we = 1'b0; addr = 7'd3;
    tick();
    req = 1'b0; rst_n = 1'b0;
    chk("flush_t0", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("flush_t1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("flush_t2", {31'd0, rsp_valid}, 32'd0);
    chk("flush_cnt", {16'd0, err_cnt}, 32'd0);

    // Partial INIT with requests held high (ignored) and a boundary load, then reset again.
    rst_n = 1'b1; req = 1'b1; we = 1'b1; addr = 7'd0; strb = 4'hF;
    n_stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) prot_we = 1'b1;
      else prot_we = 1'b0;
      prot_bound = 8'd30;
      tick();
      if (rsp_valid) n_stray++;
    end
    prot_we = 1'b0; req = 1'b0; we = 1'b0; strb = 4'h0;
    chk("init_stray", n_stray, 32'd0);
    chk("init_bound", {24'd0, prot_bound_q}, 32'd30);
    chk("init_busy_mid", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst2_bound", {24'd0, prot_bound_q}, 32'd64);
    chk("rst2_busy", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b1;
    wait_init(n_busy, n_stray);
    chk("reinit_cycles", n_busy, 32'd128);
    chk("reinit_stray", n_stray, 32'd0);
    req_rsp(1'b0, 7'd20, 32'd0, 4'h0, 1'b0, 32'd20, "rd20_reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bank_prot.md
MEM_BANK_PROT -- requirements
Module: mem_bank_prot

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, meaning word-address bits (depth = 2**ADDR_WIDTH).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width; it must be a multiple of 8.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, meaning cycles from request accept to response; legal values are 1 or 2.
REQ-004 The block SHALL have parameter RO_WORDS_RST, default 64, meaning the reset value of the protection boundary.
REQ-005 The block SHALL have port i_clk, input, 1, clock.
REQ-006 The block SHALL have port i_rst_n, input, 1, reset; it is synchronous and active-low.
REQ-007 The block SHALL have port i_req, input, 1, access request.
REQ-008 The block SHALL have port i_we, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port i_addr, input, ADDR_WIDTH, word address.
REQ-010 The block SHALL have port i_wdata, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port i_strb, input, DATA_WIDTH/8, byte-lane write enables.
REQ-012 The block SHALL have port o_ready, input-accept, output, 1; it is high when a request can be accepted.
REQ-013 The block SHALL have port o_rsp_valid, output, 1, one-cycle response pulse.
REQ-014 The block SHALL have port o_rdata, output, DATA_WIDTH, read data; it is valid with o_rsp_valid for reads.
REQ-015 The block SHALL have port o_err, output, 1, error flag; it is valid with o_rsp_valid.
REQ-016 The block SHALL have port i_prot_we, input, 1, load protection boundary.
REQ-017 The block SHALL have port i_prot_bound, input, ADDR_WIDTH+1, new boundary value.
REQ-018 The block SHALL have port o_prot_bound, output, ADDR_WIDTH+1, current boundary.
REQ-019 The block SHALL have port i_err_clr, input, 1, clear error counter.
REQ-020 The block SHALL have port o_err_cnt, output, 16, saturating count of errored writes.
REQ-021 The block SHALL have port o_init_busy, output, 1; it is high while memory initialisation runs.

Function
REQ-022 The FSM SHALL have states INIT and RUN; reset SHALL enter INIT with the init counter at 0.
REQ-023 In INIT, the block SHALL write one word per cycle: mem[n] = n, zero-extended.
REQ-024 INIT SHALL transition to RUN after word 2**ADDR_WIDTH-1 is written; it takes exactly 2**ADDR_WIDTH cycles.
REQ-025 o_ready SHALL equal (state == RUN) and o_init_busy SHALL equal (state == INIT).
REQ-026 A request SHALL be accepted in any cycle with i_req && o_ready; requests while not ready SHALL be ignored, with no response.
REQ-027 Every accepted request SHALL produce exactly one o_rsp_valid pulse, exactly RD_LATENCY cycles after accept; the path is fully pipelined at one request per cycle.
REQ-028 A read SHALL return mem[i_addr] as sampled at accept, with o_err = 0; all addresses are readable.
REQ-029 A write to i_addr < o_prot_bound SHALL be protected: memory is unchanged, the response has o_err = 1, and o_err_cnt is incremented.
REQ-030 An unprotected write SHALL update only the byte lanes with i_strb[k] = 1, at the accept clock edge, with o_err = 0.
REQ-031 A write with i_strb all zero SHALL leave memory unchanged and produce no error, even if protected.
REQ-032 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-033 i_prot_we SHALL load o_prot_bound on the next edge; values above 2**ADDR_WIDTH SHALL clamp to 2**ADDR_WIDTH.
REQ-034 A request accepted in the same cycle as i_prot_we SHALL use the old boundary.
REQ-035 i_prot_we SHALL be honoured in both INIT and RUN.
REQ-036 Boundary 0 SHALL mean everything is writable; boundary 2**ADDR_WIDTH SHALL mean everything is read-only.
REQ-037 o_err_cnt SHALL saturate at 16'hFFFF.
REQ-038 If i_err_clr and an error increment occur in the same cycle, o_err_cnt SHALL become 1.
REQ-039 If i_err_clr occurs alone, o_err_cnt SHALL become 0.
REQ-040 o_rdata SHALL be 0 when o_rsp_valid is low or the response is for a write.

Reset
REQ-041 While i_rst_n = 0, the block SHALL hold o_rsp_valid = 0, o_err = 0, o_rdata = 0, o_err_cnt = 0, o_ready = 0, o_init_busy = 1, and o_prot_bound = RO_WORDS_RST.
REQ-042 Reset SHALL flush all in-flight pipeline responses; none are emitted after reset.
REQ-043 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from word 0.

Structure
REQ-044 Package mem_bank_pkg SHALL hold the FSM state enum (INIT, RUN), the response struct (valid, err, rdata), and the error-counter width constant ERR_CNT_W = 16.
REQ-045 Sub-module mem_rsp_pipe SHALL implement the RD_LATENCY-stage response delay line with reset flush.

Verification
REQ-046 Bench scenario SHALL cover: release reset -> o_init_busy high for exactly 128 cycles; then reads of addr 0, 5, and 127 return 0, 5, and 127.
REQ-047 Bench scenario SHALL cover: write 32'hDEADBEEF with strb 4'b0101 to addr 100 (initial 100 = 32'h64) -> read returns 32'h00AD00EF with o_err = 0.
REQ-048 Bench scenario SHALL cover: write to addr 10 with bound 64 -> o_err = 1, o_err_cnt = 1, and a read of addr 10 returns 10.
REQ-049 Bench scenario SHALL cover: i_prot_we with bound 8 in the same cycle as a write to addr 20 -> error; a following write to addr 20 succeeds.
REQ-050 Bench scenario SHALL cover: RD_LATENCY = 2 with back-to-back write to addr 70 then read of addr 70 -> the read response arrives 2 cycles after its accept and returns the new data.
REQ-051 Bench scenario SHALL cover: reset asserted mid-INIT and mid-pipeline -> no stray o_rsp_valid, and INIT restarts for the full 128 cycles.
